// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the lane extension helper used by the align datapath.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } lsu_state_e;

  // Sign- or zero-extend a byte (lane[7:0]) or a halfword (lane[15:0]) to 32 bits.
  function automatic logic [31:0] extend_lane(input logic [15:0] lane,
                                              input logic        is_half,
                                              input logic        sign_ext);
    logic [31:0] r;
    if (is_half) begin
      if (sign_ext) r = {{16{lane[15]}}, lane};
      else          r = {16'd0, lane};
    end else begin
      if (sign_ext) r = {{24{lane[7]}}, lane[7:0]};
      else          r = {24'd0, lane[7:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane datapath: extracts/extends the addressed lane for loads
// and splices store data into the addressed lane of a read word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  byte_off,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_lane_s;
  logic [15:0] half_lane_s;

  // Select the addressed byte and halfword of the read word.
  always_comb begin
    byte_lane_s = rd_word[{byte_off, 3'b000} +: 8];
    half_lane_s = rd_word[{byte_off[1], 4'b0000} +: 16];
  end

  // Load path: extend the selected lane; words pass through untouched.
  always_comb begin
    load_data = 32'd0;
    case (size)
      SZ_BYTE: load_data = extend_lane({8'd0, byte_lane_s}, 1'b0, sign_ext);
      SZ_HALF: load_data = extend_lane(half_lane_s, 1'b1, sign_ext);
      SZ_WORD: load_data = rd_word;
      default: load_data = 32'd0;
    endcase
  end

  // Store path: replace only the addressed lane with right-justified wdata.
  always_comb begin
    merge_data = rd_word;
    case (size)
      SZ_BYTE: merge_data[{byte_off, 3'b000} +: 8]    = wdata[7:0];
      SZ_HALF: merge_data[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
      SZ_WORD: merge_data = wdata;
      default: merge_data = rd_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the core and word-addressed data memory; sub-word
// stores are done as a stalling two-cycle read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] dm_addr,
  output logic        dm_we,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rd
);

  localparam int HI_W = 30 - ADDR_W;

  lsu_state_e  state_r;
  lsu_state_e  state_nxt_s;
  logic [31:0] merge_r;
  logic [29:0] idx_r;
  logic [31:0] fault_addr_r;

  logic        access_s;
  logic        load_s;
  logic        align_err_s;
  logic        range_err_s;
  logic        fault_s;
  logic        word_store_s;
  logic        sub_store_s;
  logic [31:0] load_data_s;
  logic [31:0] merge_data_s;

  lsu_lane_align u_align (
    .byte_off   (addr[1:0]),
    .size       (size),
    .sign_ext   (sign_ext),
    .rd_word    (dm_rd),
    .wdata      (wdata),
    .load_data  (load_data_s),
    .merge_data (merge_data_s)
  );

  // Alignment check per size; the reserved size always faults.
  always_comb begin
    align_err_s = 1'b0;
    case (size)
      SZ_BYTE: align_err_s = 1'b0;
      SZ_HALF: align_err_s = addr[0];
      SZ_WORD: align_err_s = (addr[1:0] != 2'b00);
      default: align_err_s = 1'b1;
    endcase
  end

  // Request decode; a simultaneous read and write is handled as a store.
  always_comb begin
    access_s     = mem_read | mem_write;
    load_s       = mem_read & ~mem_write;
    range_err_s  = (addr[31:ADDR_W+2] != {HI_W{1'b0}});
    fault_s      = access_s & (align_err_s | range_err_s);
    word_store_s = mem_write & ~fault_s & (size == SZ_WORD);
    sub_store_s  = mem_write & ~fault_s & ((size == SZ_BYTE) | (size == SZ_HALF));
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // FSM next state: a sub-word store spends exactly one cycle in RMW_WR.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (sub_store_s) state_nxt_s = ST_RMW_WR;
        else             state_nxt_s = ST_IDLE;
      end
      ST_RMW_WR: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Merge word and target index captured on the read half of the RMW.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      merge_r <= 32'd0;
      idx_r   <= 30'd0;
    end else if ((state_r == ST_IDLE) && sub_store_s) begin
      merge_r <= merge_data_s;
      idx_r   <= addr[31:2];
    end
  end

  // Address of the most recent faulting access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        fault_addr_r <= 32'd0;
    else if (fault_s) fault_addr_r <= addr;
  end

  // FSM outputs: memory port and stall.
  always_comb begin
    stall    = 1'b0;
    dm_we    = 1'b0;
    dm_wdata = 32'd0;
    dm_addr  = {2'b00, addr[31:2]};
    case (state_r)
      ST_IDLE: begin
        if (word_store_s) begin
          dm_we    = 1'b1;
          dm_wdata = wdata;
        end else if (sub_store_s) begin
          stall    = 1'b1;
        end else begin
          dm_we    = 1'b0;
        end
      end
      ST_RMW_WR: begin
        dm_addr  = {2'b00, idx_r};
        dm_we    = 1'b1;
        dm_wdata = merge_r;
      end
      default: begin
        dm_we    = 1'b0;
      end
    endcase
  end

  // Load data and fault reporting.
  always_comb begin
    if (load_s && !fault_s) rdata = load_data_s;
    else                    rdata = 32'd0;
    fault      = fault_s;
    fault_addr = fault_addr_r;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a transaction-level
// model of the memory, plus hand-computed expectations for the key scenarios.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata, fault_addr, dm_addr, dm_wdata, dm_rd;
  logic        stall, fault, dm_we;

  load_store_unit #(.ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .fault(fault), .fault_addr(fault_addr),
    .dm_addr(dm_addr), .dm_we(dm_we), .dm_wdata(dm_wdata), .dm_rd(dm_rd)
  );

  always #5 clk = ~clk;

  // Environment memory seen by the DUT.
  logic [31:0] mem [0:65535];
  assign dm_rd = mem[dm_addr[15:0]];
  always @(posedge clk) if (dm_we) mem[dm_addr[15:0]] <= dm_wdata;

  // Reference memory contents as the model believes them.
  logic [31:0] ref_mem [0:65535];

  int n_checks = 0;
  int n_fail   = 0;

  logic        chk_en = 1'b0;
  logic        chk_rdata;
  logic [31:0] exp_rdata, exp_fault_addr, exp_dm_addr, exp_wdata;
  logic        exp_stall, exp_fault, exp_we;

  logic [31:0] c1_rdata, c1_addr, c2_addr, c2_wdata;
  logic        c1_stall, c1_we, c1_fault, c2_we, c2_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model's expectations.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      if (chk_rdata) chk("rdata", rdata, exp_rdata);
      chk("stall", {31'd0, stall}, {31'd0, exp_stall});
      chk("fault", {31'd0, fault}, {31'd0, exp_fault});
      chk("fault_addr", fault_addr, exp_fault_addr);
      chk("dm_addr", dm_addr, exp_dm_addr);
      chk("dm_we", {31'd0, dm_we}, {31'd0, exp_we});
      chk("dm_wdata", dm_wdata, exp_wdata);
    end
  end

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] lo,
                                             input logic [1:0] sz, input logic sx);
    logic [31:0] v;
    case (sz)
      2'd0: begin
        v = (w >> (8 * lo)) & 32'd255;
        if (sx && v >= 32'd128) v = v - 32'd256;
      end
      2'd1: begin
        v = (w >> (16 * lo[1])) & 32'd65535;
        if (sx && v >= 32'd32768) v = v - 32'd65536;
      end
      2'd2:    v = w;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [1:0] lo,
                                              input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] mask;
    int          sh;
    if (sz == 2'd0) begin mask = 32'd255;   sh = 8 * lo;     end
    else            begin mask = 32'd65535; sh = 16 * lo[1]; end
    return (w & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  // One CPU access; inputs are held through the stall and the write-back cycle.
  task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic sx, input logic [31:0] a, input logic [31:0] wd);
    logic        f;
    logic [15:0] idx;
    f   = (rd | wr) && (sz == 2'd3 || (sz == 2'd1 && a[0]) ||
                        (sz == 2'd2 && a[1:0] != 2'd0) || a >= 32'h0004_0000);
    idx = a[17:2];
    mem_read = rd; mem_write = wr; size = sz; sign_ext = sx; addr = a; wdata = wd;
    exp_dm_addr = {2'b00, a[31:2]};
    exp_fault = f; exp_rdata = 32'd0; exp_stall = 1'b0; exp_we = 1'b0; exp_wdata = 32'd0;
    chk_rdata = 1'b1;
    if (!f && wr) begin
      chk_rdata = !rd;
      if (sz == 2'd2) begin exp_we = 1'b1; exp_wdata = wd; end
      else            exp_stall = 1'b1;
    end else if (!f && rd) begin
      exp_rdata = model_load(ref_mem[idx], a[1:0], sz, sx);
    end
    @(negedge clk); #1;
    c1_rdata = rdata; c1_stall = stall; c1_we = dm_we; c1_fault = fault; c1_addr = dm_addr;
    @(posedge clk); #1;
    if (f) exp_fault_addr = a;
    c2_we = 1'b0; c2_stall = 1'b0; c2_addr = 32'd0; c2_wdata = 32'd0;
    if (!f && wr) begin
      if (sz == 2'd2) begin
        ref_mem[idx] = wd;
      end else begin
        exp_stall = 1'b0; exp_we = 1'b1;
        exp_wdata = model_merge(ref_mem[idx], a[1:0], sz, wd);
        ref_mem[idx] = exp_wdata;
        @(negedge clk); #1;
        c2_we = dm_we; c2_stall = stall; c2_addr = dm_addr; c2_wdata = dm_wdata;
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    logic [31:0] v;
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; size = 2'd0; sign_ext = 1'b0;
    addr = 32'd0; wdata = 32'd0; chk_rdata = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      if (i < 32 || i >= 65532) v = $urandom; else v = 32'd0;
      if (i == 0) v = 32'h8081_7F02;
      if (i == 3) v = 32'h1122_3344;
      mem[i] <= v;
      ref_mem[i] = v;
    end
    exp_fault_addr = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // Reset state with idle inputs.
    run_access(1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_0010, 32'd0);
    chk("idle_rdata", c1_rdata, 32'd0);
    chk("idle_stall", {31'd0, c1_stall}, 32'd0);
    chk("idle_we", {31'd0, c1_we}, 32'd0);
    chk("idle_dm_addr", c1_addr, 32'd4);
    chk("idle_fault_addr", fault_addr, 32'd0);

    // Sub-word loads from 32'h8081_7F02.
    run_access(1'b1, 1'b0, 2'd0, 1'b1, 32'd1, 32'd0);
    chk("lb_1_sx", c1_rdata, 32'h0000_007F);
    run_access(1'b1, 1'b0, 2'd0, 1'b1, 32'd3, 32'd0);
    chk("lb_3_sx", c1_rdata, 32'hFFFF_FF80);
    run_access(1'b1, 1'b0, 2'd0, 1'b0, 32'd3, 32'd0);
    chk("lb_3_zx", c1_rdata, 32'h0000_0080);
    run_access(1'b1, 1'b0, 2'd1, 1'b1, 32'd2, 32'd0);
    chk("lh_2_sx", c1_rdata, 32'hFFFF_8081);

    // Reset during RMW_WR aborts the write.
    chk_en = 1'b0;
    mem_read = 1'b0; mem_write = 1'b1; size = 2'd0; addr = 32'd0; wdata = 32'h0000_0055;
    @(negedge clk); #1;
    chk("rst_rmw_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    chk("rst_rmw_we_on", {31'd0, dm_we}, 32'd1);
    reset = 1'b1; #1;
    chk("rst_rmw_we_drop", {31'd0, dm_we}, 32'd0);
    mem_write = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    exp_fault_addr = 32'd0;
    chk("rst_rmw_stall_off", {31'd0, stall}, 32'd0);
    chk_en = 1'b1;
    run_access(1'b1, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0);
    chk("rst_rmw_mem_kept", c1_rdata, 32'h8081_7F02);

    // Word store and read-back.
    run_access(1'b0, 1'b1, 2'd2, 1'b0, 32'd8, 32'hDEAD_BEEF);
    chk("sw_we", {31'd0, c1_we}, 32'd1);
    chk("sw_dm_addr", c1_addr, 32'd2);
    chk("sw_stall", {31'd0, c1_stall}, 32'd0);
    run_access(1'b1, 1'b0, 2'd2, 1'b0, 32'd8, 32'd0);
    chk("lw_8", c1_rdata, 32'hDEAD_BEEF);

    // Byte store read-modify-write into 32'h1122_3344.
    run_access(1'b0, 1'b1, 2'd0, 1'b0, 32'd13, 32'h0000_00AA);
    chk("sb_c1_stall", {31'd0, c1_stall}, 32'd1);
    chk("sb_c1_we", {31'd0, c1_we}, 32'd0);
    chk("sb_c2_we", {31'd0, c2_we}, 32'd1);
    chk("sb_c2_addr", c2_addr, 32'd3);
    chk("sb_c2_wdata", c2_wdata, 32'h1122_AA44);
    run_access(1'b0, 1'b0, 2'd0, 1'b0, 32'd13, 32'd0);
    chk("sb_c3_stall", {31'd0, c1_stall}, 32'd0);
    chk("sb_c3_we", {31'd0, c1_we}, 32'd0);

    // Faults and address-range boundaries.
    run_access(1'b0, 1'b1, 2'd1, 1'b0, 32'd5, 32'h0000_1234);
    chk("sh5_fault", {31'd0, c1_fault}, 32'd1);
    chk("sh5_we", {31'd0, c1_we}, 32'd0);
    chk("sh5_stall", {31'd0, c1_stall}, 32'd0);
    chk("sh5_fault_addr", fault_addr, 32'd5);
    run_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h0004_0000, 32'd0);
    chk("lw_oor_fault", {31'd0, c1_fault}, 32'd1);
    run_access(1'b1, 1'b0, 2'd0, 1'b0, 32'h0003_FFFF, 32'd0);
    chk("lb_top_fault", {31'd0, c1_fault}, 32'd0);
    run_access(1'b0, 1'b1, 2'd0, 1'b0, 32'h0004_0000, 32'd0);
    chk("sb_oor_fault", {31'd0, c1_fault}, 32'd1);
    chk("sb_oor_stall", {31'd0, c1_stall}, 32'd0);

    // Back-to-back half store then word store to the same word.
    run_access(1'b0, 1'b1, 2'd1, 1'b0, 32'd6, 32'h0000_BEEF);
    chk("b2b_half_stall", {31'd0, c1_stall}, 32'd1);
    run_access(1'b0, 1'b1, 2'd2, 1'b0, 32'd4, 32'hCAFE_F00D);
    run_access(1'b1, 1'b0, 2'd2, 1'b0, 32'd4, 32'd0);
    chk("b2b_final", c1_rdata, 32'hCAFE_F00D);

    // Randomized traffic.
    for (int n = 0; n < 500; n++) begin
      int          kind, ak;
      logic [1:0]  sz;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) sz = 2'd3;
      else                           sz = 2'($urandom_range(0, 2));
      ak = $urandom_range(0, 15);
      if (ak == 0)      a = $urandom | 32'h0004_0000;
      else if (ak == 1) a = 32'h0003_FFF0 + 32'($urandom_range(0, 15));
      else              a = 32'($urandom_range(0, 127));
      if (kind <= 3)      run_access(1'b1, 1'b0, sz, 1'($urandom_range(0, 1)), a, $urandom);
      else if (kind <= 7) run_access(1'b0, 1'b1, sz, 1'($urandom_range(0, 1)), a, $urandom);
      else if (kind == 8) run_access(1'b1, 1'b1, sz, 1'($urandom_range(0, 1)), a, $urandom);
      else                run_access(1'b0, 1'b0, sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    // Sweep the model's memory image through word loads.
    for (int w = 0; w < 32; w++) begin
      run_access(1'b1, 1'b0, 2'd2, 1'b0, 32'(w * 4), 32'd0);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
